// File: rtl/msrv_32_alu_arb_pkg.sv
// rtl/msrv_32_alu_arb_pkg.sv - shared types and constants for the ALU arbiter
package msrv_32_alu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // ALU opcodes as {funct7[5], funct3}
    localparam logic [3:0] FUNCT3_ADD  = 4'b0000;
    localparam logic [3:0] FUNCT3_SLL  = 4'b0001;
    localparam logic [3:0] FUNCT3_SLT  = 4'b0010;
    localparam logic [3:0] FUNCT3_SLTU = 4'b0011;
    localparam logic [3:0] FUNCT3_XOR  = 4'b0100;
    localparam logic [3:0] FUNCT3_SRL  = 4'b0101;
    localparam logic [3:0] FUNCT3_OR   = 4'b0110;
    localparam logic [3:0] FUNCT3_AND  = 4'b0111;
    localparam logic [3:0] FUNCT3_SUB  = 4'b1000;
    localparam logic [3:0] FUNCT3_SRA  = 4'b1101;

    // Requester identifiers
    localparam logic REQ_ID_0 = 1'b0;  // integer pipeline
    localparam logic REQ_ID_1 = 1'b1;  // multi-cycle helper

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    function automatic logic rr_pick(input logic valid_0, input logic valid_1,
                                     input logic last_grant);
        if (valid_0 && valid_1) begin
            return ~last_grant;
        end
        return (valid_1 && !valid_0) ? REQ_ID_1 : REQ_ID_0;
    endfunction

endpackage

// File: rtl/msrv_32_rr_arbiter.sv
// rtl/msrv_32_rr_arbiter.sv - 2-way grant logic; MSRV32_ALU_ARB_FIXED_PRIO_EN selects fixed priority
module msrv_32_rr_arbiter
    import msrv_32_alu_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid_0,
    input  logic valid_1,
    input  logic accept,
    output logic grant_id
);

`ifdef MSRV32_ALU_ARB_FIXED_PRIO_EN
    // Requester 0 always wins a tie; no history is kept
    always_comb begin
        grant_id = (valid_1 && !valid_0) ? REQ_ID_1 : REQ_ID_0;
    end
`else
    logic last_grant;

    // Remember the previous owner, updated only when a request is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_ID_1;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

    // Alternate on ties so neither requester can starve the other
    always_comb begin
        grant_id = rr_pick(valid_0, valid_1, last_grant);
    end
`endif

endmodule

// File: rtl/msrv_32_alu_arbiter.sv
// rtl/msrv_32_alu_arbiter.sv - shares one ALU between the pipeline and the helper unit
module msrv_32_alu_arbiter
    import msrv_32_alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              req0_valid_in,
    output logic              req0_ready_out,
    input  logic [DATA_W-1:0] req0_op_1_in,
    input  logic [DATA_W-1:0] req0_op_2_in,
    input  logic [OPC_W-1:0]  req0_opcode_in,
    input  logic              req1_valid_in,
    output logic              req1_ready_out,
    input  logic [DATA_W-1:0] req1_op_1_in,
    input  logic [DATA_W-1:0] req1_op_2_in,
    input  logic [OPC_W-1:0]  req1_opcode_in,
    output logic              rsp0_valid_out,
    input  logic              rsp0_ready_in,
    output logic              rsp1_valid_out,
    input  logic              rsp1_ready_in,
    output logic [DATA_W-1:0] rsp_result_out,
    output logic [DATA_W-1:0] alu_op_1_out,
    output logic [DATA_W-1:0] alu_op_2_out,
    output logic [OPC_W-1:0]  alu_opcode_out,
    input  logic [DATA_W-1:0] alu_result_in
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              owner_q;
    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] op_1_q;
    logic [DATA_W-1:0] op_2_q;
    logic [OPC_W-1:0]  opcode_q;
    logic [DATA_W-1:0] result_q;

    msrv_32_rr_arbiter u_rr_arbiter (
        .clk      (ms_riscv32_mp_clk_in),
        .rst_n    (ms_riscv32_mp_rst_in),
        .valid_0  (req0_valid_in),
        .valid_1  (req1_valid_in),
        .accept   (accept),
        .grant_id (grant_id)
    );

    // FSM state register
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready is held low while reset is asserted
    always_comb begin
        state_d        = state_q;
        req0_ready_out = 1'b0;
        req1_ready_out = 1'b0;
        rsp0_valid_out = 1'b0;
        rsp1_valid_out = 1'b0;
        accept         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (ms_riscv32_mp_rst_in) begin
                    req0_ready_out = req0_valid_in && (grant_id == REQ_ID_0);
                    req1_ready_out = req1_valid_in && (grant_id == REQ_ID_1);
                end
                accept = req0_ready_out || req1_ready_out;
                if (accept) begin
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                rsp0_valid_out = (owner_q == REQ_ID_0);
                rsp1_valid_out = (owner_q == REQ_ID_1);
                if ((rsp0_valid_out && rsp0_ready_in) || (rsp1_valid_out && rsp1_ready_in)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, result capture at the end of EXEC
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            owner_q  <= REQ_ID_0;
            op_1_q   <= '0;
            op_2_q   <= '0;
            opcode_q <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                owner_q  <= grant_id;
                op_1_q   <= (grant_id == REQ_ID_1) ? req1_op_1_in   : req0_op_1_in;
                op_2_q   <= (grant_id == REQ_ID_1) ? req1_op_2_in   : req0_op_2_in;
                opcode_q <= (grant_id == REQ_ID_1) ? req1_opcode_in : req0_opcode_in;
            end
            if (state_q == ARB_EXEC) begin
                result_q <= alu_result_in;
            end
        end
    end

    assign alu_op_1_out   = op_1_q;
    assign alu_op_2_out   = op_2_q;
    assign alu_opcode_out = opcode_q;
    assign rsp_result_out = result_q;

endmodule

// File: doc/msrv_32_alu_arbiter.md
# msrv_32_alu_arbiter

Shares one combinational `msrv_32_alu` between two requesters: requester 0 is the integer pipeline and requester 1 is the multi-cycle helper unit. The block arbitrates valid/ready requests, registers the winning operands, drives the shared ALU and holds the result in a response register until the owning requester accepts it. It sits between the requesters and the single ALU instance in the core.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width (must match ALU)
- `OPC_W`, 4, ALU opcode width ({funct7[5], funct3})

Ports (x = 0, 1):
- `ms_riscv32_mp_clk_in`  in  1  clock, rising edge
- `ms_riscv32_mp_rst_in`  in  1  reset, asynchronous, active-low
- `reqx_valid_in`  in  1  requester x has a request
- `reqx_ready_out`  out  1  request x accepted this cycle
- `reqx_op_1_in`, `reqx_op_2_in`  in  DATA_W  operands
- `reqx_opcode_in`  in  OPC_W  ALU opcode
- `rspx_valid_out`  out  1  result for x available
- `rspx_ready_in`  in  1  requester x takes result
- `rsp_result_out`  out  DATA_W  result (shared; qualified by `rspx_valid_out`)
- `alu_op_1_out`, `alu_op_2_out`  out  DATA_W  to ALU `op_1_in`/`op_2_in`
- `alu_opcode_out`  out  OPC_W  to ALU `opcode_in`
- `alu_result_in`  in  DATA_W  from ALU `result_out`

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbiter picks a grant among the valid requesters.
  - `reqg_ready_out`=1 combinationally for the granted requester only; the handshake is `valid & ready`.
  - On the handshake, latch operands/opcode into the operand register and record the owner; go to EXEC.
- EXEC:
  - ALU ports are driven from the operand register.
  - At the clock edge, capture `alu_result_in` into the result register; go to RESP.
- RESP:
  - `rsp<owner>_valid_out`=1 and `rsp_result_out` = result register.
  - On `rsp<owner>_ready_in`=1, go to IDLE.
  - No new request is accepted in RESP or EXEC; all `ready` outputs are 0.
- Round-robin: a `last_grant` register holds the previous owner.
  - With both requesters valid, the grant goes to `!last_grant`.
  - With a single requester valid, that requester wins.
  - `last_grant` updates only on a request handshake.
- Requester rules: `valid`, operands and opcode must hold stable until `ready`. Dropping `valid` before `ready` is legal and cancels the request, with no state change.
- The opcode passes through unchanged. The block never interprets opcodes, so the arithmetic width is the ALU's (32-bit wrap, shift amount `op_2[4:0]`).
- `rsp_ready_in` of the non-owner is ignored.
- Reset (asserted any time, including mid-EXEC/RESP):
  - State returns to IDLE and any in-flight request is discarded.
  - `last_grant`=1, so requester 0 wins first.
  - All outputs are 0; operand and result registers are 0.

## Timing
- The request handshake at edge N gives EXEC in cycle N..N+1.
- `rspx_valid_out` rises after edge N+1: 2-cycle latency from acceptance to response.
- Response accept at edge M puts the FSM in IDLE in cycle M+1. The next handshake can occur in that cycle, giving a minimum of 3 cycles per operation.
- `ready` outputs depend combinationally on `valid` inputs and the state.
- ALU outputs are registered (stable for all of EXEC and RESP).
- `alu_result_in` is sampled only at the EXEC→RESP edge.

## Configuration
- `MSRV32_ALU_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 always wins when both are valid.
  - `last_grant` is not implemented.
- Undefined (default): round-robin as described above.

## Structure
- Package `msrv_32_alu_arb_pkg`:
  - State enum (IDLE/EXEC/RESP).
  - Opcode constants `FUNCT3_ADD`=4'b0000, `FUNCT3_SRL`=4'b0101, etc. (shared with benches).
  - Requester ID constants.
- Sub-module `msrv_32_rr_arbiter`: 2-way grant logic plus the `last_grant` register. It is compiled to fixed priority under the macro.

## Test plan
- Reset, then r0 sends add op1=5, op2=3 → `req0_ready_out`=1 at the handshake; `rsp0_valid_out`=1 two cycles later with `rsp_result_out`=8; `rsp1_valid_out`=0.
- r1 alone sends SRL op1=16, op2=3 (opcode 4'b0101) → `rsp1_valid_out`, result=2.
- Both valid continuously after reset → grants r0, r1, r0, r1. Under `MSRV32_ALU_ARB_FIXED_PRIO_EN` → r0, r0, r0.
- r0 response held with `rsp0_ready_in`=0 for 5 cycles while r1 is valid → result stays 8, `req1_ready_out` stays 0; r1 is granted in the cycle after release.
- Assert reset during EXEC → all outputs 0 immediately, no response is ever issued. After release, the first request from both valid goes to r0.
- r0 raises then drops `valid` in IDLE before the handshake while r1 is busy elsewhere → no state change and `last_grant` unchanged.
